// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: opcodes, memory-sequencer states and field widths.
// Imported by the core and by the memory sequencer.
package mu0_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef enum logic [3:0] {
        LDA = 4'd0,
        STO = 4'd1,
        ADD = 4'd2,
        SUB = 4'd3,
        JMP = 4'd4,
        JGE = 4'd5,
        JNE = 4'd6,
        STP = 4'd7,
        OUT = 4'd8
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        OPERAND = 3'd3,
        STORE   = 3'd4,
        EXEC    = 3'd5,
        HALT    = 3'd6
    } seq_state_t;

    // Opcodes whose execute step consumes a word read from instr[11:0].
    function automatic logic needs_operand(input opcode_t op);
        return (op == LDA) || (op == ADD) || (op == SUB);
    endfunction

endpackage

// File: rtl/mu0_req_timer.sv
// Per-request wait counter: counts cycles spent waiting for mem_ack and flags
// the cycle in which the count reaches TIMEOUT.
module mu0_req_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_wait,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    // Saturates at TIMEOUT so a stalled sequencer never wraps back to zero.
    always_ff @(posedge clk) begin
        if (rst || i_clear)
            r_cnt <= '0;
        else if (i_wait && (r_cnt != CW'(TIMEOUT)))
            r_cnt <= r_cnt + 1'b1;
    end

    // Fires in the wait cycle whose increment makes the count hit TIMEOUT,
    // so the owner can drop the request on that same edge.
    assign o_expired = i_wait && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mu0_mem_sequencer.sv
// MU0 memory sequencer: fetches an instruction, performs the operand read or
// store it needs over a single-port memory, then strobes the core to execute.
module mu0_mem_sequencer
    import mu0_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              running,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] readdata,
    output logic              validRead,
    output logic              mem_req,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    seq_state_t        r_state;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_readdata;
    logic              r_valid;
    logic              r_mem_req;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_err;

    opcode_t w_op;
    logic    w_clear;
    logic    w_wait;
    logic    w_expired;

    assign w_op   = opcode_t'(r_instr[15:12]);
    assign w_wait = r_mem_req && !mem_ack;

    // Clear on every transition into a request state.
    assign w_clear = ((r_state == IDLE) && running) ||
                     ((r_state == DECODE) && (needs_operand(w_op) || (w_op == STO)));

    mu0_req_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_wait    (w_wait),
        .o_expired (w_expired)
    );

    // Request outputs are registered on the transition into each state, so a
    // zero-wait memory sees mem_req in the first cycle of FETCH/OPERAND/STORE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_instr     <= '0;
            r_readdata  <= '0;
            r_valid     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_err       <= 1'b0;
        end else if (w_expired) begin
            r_err       <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_write <= 1'b0;
            r_state     <= HALT;
        end else begin
            case (r_state)
                IDLE: begin
                    if (running) begin
                        r_state     <= FETCH;
                        r_mem_req   <= 1'b1;
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= pc;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        r_instr   <= mem_rdata;
                        r_mem_req <= 1'b0;
                        r_state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (needs_operand(w_op)) begin
                        r_state     <= OPERAND;
                        r_mem_req   <= 1'b1;
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= r_instr[11:0];
                    end else if (w_op == STO) begin
                        r_state     <= STORE;
                        r_mem_req   <= 1'b1;
                        r_mem_write <= 1'b1;
                        r_mem_addr  <= r_instr[11:0];
                        r_mem_wdata <= writedata;
                    end else begin
                        r_state <= EXEC;
                        r_valid <= 1'b1;
                    end
                end
                OPERAND: begin
                    if (mem_ack) begin
                        r_readdata <= mem_rdata;
                        r_mem_req  <= 1'b0;
                        r_valid    <= 1'b1;
                        r_state    <= EXEC;
                    end
                end
                STORE: begin
                    if (mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_valid     <= 1'b1;
                        r_state     <= EXEC;
                    end
                end
                EXEC: begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state   <= IDLE;
                    r_valid   <= 1'b0;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign instr     = r_instr;
    assign readdata  = r_readdata;
    assign validRead = r_valid;
    assign mem_req   = r_mem_req;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign err       = r_err;

endmodule

// File: tb/tb_mu0_mem_sequencer.sv
// Directed bench for mu0_mem_sequencer with a ROM/ack model and an event
// scoreboard checked whenever a request is accepted or validRead strobes.
module tb_mu0_mem_sequencer;

    localparam int EV_RD = 0;
    localparam int EV_WR = 1;
    localparam int EV_EX = 2;

    typedef struct {
        int          kind;
        logic [11:0] addr;
        logic [15:0] d0;
        logic [15:0] d1;
    } ev_t;

    logic        clk, rst, running;
    logic [11:0] pc;
    logic [15:0] writedata;
    logic [15:0] instr, readdata, mem_wdata, mem_rdata;
    logic        validRead, mem_req, mem_write, mem_ack, err;
    logic [11:0] mem_addr;

    logic [15:0] mem [0:4095];
    int          ack_delay, delay_addr, req_cnt;
    logic        ack_never, spur_ack;

    ev_t sb[$];
    int  n_cmp, n_fail, wr_count;

    mu0_mem_sequencer #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .running   (running),
        .pc        (pc),
        .writedata (writedata),
        .instr     (instr),
        .readdata  (readdata),
        .validRead (validRead),
        .mem_req   (mem_req),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: ack after ack_delay waiting cycles on delay_addr, else at once.
    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = spur_ack ||
                       (mem_req && !ack_never &&
                        (req_cnt >= ((int'(mem_addr) == delay_addr) ? ack_delay : 0)));

    always @(posedge clk) begin
        if (!mem_req || mem_ack) req_cnt <= 0;
        else                     req_cnt <= req_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int kind, input logic [11:0] a, input logic [15:0] d0,
                        input logic [15:0] d1);
        ev_t e;
        e.kind = kind; e.addr = a; e.d0 = d0; e.d1 = d1;
        sb.push_back(e);
    endtask

    logic        prev_wait, prev_write;
    logic [11:0] prev_addr;
    logic [15:0] prev_wdata;
    initial prev_wait = 1'b0;

    always @(negedge clk) begin
        ev_t e;
        if (!rst && mem_req === 1'b1) begin
            if (prev_wait) begin
                check("hold_addr", 32'(mem_addr), 32'(prev_addr));
                check("hold_write", 32'(mem_write), 32'(prev_write));
                check("hold_wdata", 32'(mem_wdata), 32'(prev_wdata));
            end
            if (mem_ack === 1'b1) begin
                check("sb_req_pending", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("req_kind", mem_write ? EV_WR : EV_RD, e.kind);
                    check("req_addr", 32'(mem_addr), 32'(e.addr));
                    if (mem_write === 1'b1) begin
                        check("req_wdata", 32'(mem_wdata), 32'(e.d0));
                        wr_count++;
                    end
                end
            end
        end
        if (!rst && validRead === 1'b1) begin
            check("sb_exec_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("exec_kind", EV_EX, e.kind);
                check("exec_instr", 32'(instr), 32'(e.d0));
                check("exec_readdata", 32'(readdata), 32'(e.d1));
            end
        end
        prev_wait  <= !rst && (mem_req === 1'b1) && (mem_ack === 1'b0);
        prev_addr  <= mem_addr;
        prev_write <= mem_write;
        prev_wdata <= mem_wdata;
    end

    // Start one instruction from IDLE; running is dropped once FETCH is under way.
    task automatic run_instr(input string tag, input int exp_lat, input int exp_reqs);
        int lat, reqs, act;
        bit seen;
        lat = 0; reqs = 0; act = 0; seen = 1'b0;
        @(posedge clk); #1 running = 1'b1;
        for (int c = 1; c <= 60 && !seen; c++) begin
            @(negedge clk);
            if (c == 2) running = 1'b0;
            if (mem_req === 1'b1) reqs++;
            if (validRead === 1'b1) begin seen = 1'b1; lat = c; end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_req_cycles"}, reqs, exp_reqs);
        repeat (3) begin
            @(negedge clk);
            if (mem_req !== 1'b0 || validRead !== 1'b0) act++;
        end
        check({tag, "_quiet"}, act, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  reqs, act;
        bit  got;
        n_cmp = 0; n_fail = 0; wr_count = 0;
        rst = 1'b1; running = 1'b0; pc = '0; writedata = '0;
        ack_delay = 0; delay_addr = -1; ack_never = 1'b0; spur_ack = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[0]  = 16'h0005; mem[5]  = 16'h1234;
        mem[1]  = 16'h1007;
        mem[2]  = 16'h4003;
        mem[3]  = 16'h2009; mem[9]  = 16'h00AA;
        mem[4]  = 16'h300A; mem[10] = 16'h5555;
        mem[6]  = 16'h8000;
        mem[8]  = 16'h0003;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_write", 32'(mem_write), 0);
        check("rst_validRead", 32'(validRead), 0);
        check("rst_err", 32'(err), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_instr", 32'(instr), 0);
        check("rst_readdata", 32'(readdata), 0);
        @(posedge clk); #1 rst = 1'b0;

        // LDA 5, zero-wait
        pc = 12'd0;
        push(EV_RD, 12'd0, '0, '0);
        push(EV_RD, 12'd5, '0, '0);
        push(EV_EX, '0, 16'h0005, 16'h1234);
        run_instr("lda", 5, 2);

        // STO 7 with writedata 0xBEEF
        pc = 12'd1; writedata = 16'hBEEF;
        push(EV_RD, 12'd1, '0, '0);
        push(EV_WR, 12'd7, 16'hBEEF, '0);
        push(EV_EX, '0, 16'h1007, 16'h1234);
        run_instr("sto", 5, 2);
        check("sto_writes", wr_count, 1);

        // JMP 3 with a stray ack held high outside requests
        pc = 12'd2; spur_ack = 1'b1;
        push(EV_RD, 12'd2, '0, '0);
        push(EV_EX, '0, 16'h4003, 16'h1234);
        run_instr("jmp", 4, 1);
        spur_ack = 1'b0;

        // SUB 10 and OUT: other operand/no-operand opcodes
        pc = 12'd4;
        push(EV_RD, 12'd4, '0, '0);
        push(EV_RD, 12'd10, '0, '0);
        push(EV_EX, '0, 16'h300A, 16'h5555);
        run_instr("sub", 5, 2);
        pc = 12'd6;
        push(EV_RD, 12'd6, '0, '0);
        push(EV_EX, '0, 16'h8000, 16'h5555);
        run_instr("out", 4, 1);

        // ADD 9 with the operand ack delayed 3 cycles
        pc = 12'd3; delay_addr = 9; ack_delay = 3;
        push(EV_RD, 12'd3, '0, '0);
        push(EV_RD, 12'd9, '0, '0);
        push(EV_EX, '0, 16'h2009, 16'h00AA);
        run_instr("add_wait", 8, 5);
        ack_delay = 0; delay_addr = -1;

        // No ack at all: timeout into HALT, held until reset
        pc = 12'd8; ack_never = 1'b1;
        reqs = 0; got = 1'b0;
        @(posedge clk); #1 running = 1'b1;
        for (int c = 1; c <= 60 && !got; c++) begin
            @(negedge clk);
            if (mem_req === 1'b1) reqs++;
            if (err === 1'b1) got = 1'b1;
        end
        check("to_err", 32'(err), 1);
        check("to_req_cycles", reqs, 16);
        check("to_req_low", 32'(mem_req), 0);
        act = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req !== 1'b0 || validRead !== 1'b0 || err !== 1'b1) act++;
        end
        check("to_halt_held", act, 0);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("to_rst_err", 32'(err), 0);
        check("to_rst_req", 32'(mem_req), 0);
        @(posedge clk); #1 rst = 1'b0; running = 1'b0; ack_never = 1'b0;

        // Reset in the middle of a stalled STORE
        pc = 12'd1; writedata = 16'h1111; delay_addr = 7; ack_delay = 5;
        push(EV_RD, 12'd1, '0, '0);
        got = 1'b0;
        @(posedge clk); #1 running = 1'b1;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (c == 2) running = 1'b0;
            if (mem_write === 1'b1 && mem_req === 1'b1) got = 1'b1;
        end
        check("st_reached", 32'(got), 1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("st_rst_req", 32'(mem_req), 0);
        check("st_rst_write", 32'(mem_write), 0);
        check("st_rst_addr", 32'(mem_addr), 0);
        check("st_rst_wdata", 32'(mem_wdata), 0);
        check("st_rst_instr", 32'(instr), 0);
        check("st_rst_readdata", 32'(readdata), 0);
        @(posedge clk); #1 rst = 1'b0;
        ack_delay = 0; delay_addr = -1; pc = 12'd2;
        push(EV_RD, 12'd2, '0, '0);
        push(EV_EX, '0, 16'h4003, 16'h0000);
        run_instr("post_rst", 4, 1);

        check("sb_drained", sb.size(), 0);
        check("wr_total", wr_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
